// File: rtl/flattening_layer_pkg.sv
// Shared definitions for the flattening layer.
// - pixel_t     : pixel word at the default width. Modules with a different BitSize declare
//                 their own words as logic [BitSize-1:0].
// - StIdle/StEmit : emit FSM states.
// - cnt_width() : counter width helper, never narrower than one bit.
package flattening_layer_pkg;

  localparam int unsigned DefBitSize = 4;

  typedef logic [DefBitSize-1:0] pixel_t;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StEmit = 1'b1;

  // Bits needed to encode values 0..n-1; at least one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/flattening_layer_lane_router.sv
// Combinational lane router for the flattening layer.
// Pairs the set bits of i_valid, taken in ascending image order, with lanes 0,1,2,...
// Set bits beyond the last lane get no write enable.
// Ports:
//   i_valid [NumOfImages]          one bit per image: a pixel for image k is present
//   i_data  [Lanes*BitSize]        pixel lanes, lane 0 in the LSBs
//   o_we    [NumOfImages]          per-image write enable
//   o_wdata [NumOfImages*BitSize]  per-image write data, image 0 in the LSBs
module flattening_layer_lane_router #(
  parameter int unsigned BitSize     = 4,
  parameter int unsigned NumOfImages = 4,
  parameter int unsigned Lanes       = 2
) (
  input  logic [NumOfImages-1:0]         i_valid,
  input  logic [Lanes*BitSize-1:0]       i_data,
  output logic [NumOfImages-1:0]         o_we,
  output logic [NumOfImages*BitSize-1:0] o_wdata
);

  // The lane of image k is the popcount of i_valid[k-1:0]. It is built as a running count.
  always_comb begin
    int unsigned lane;
    lane    = 0;
    o_we    = '0;
    o_wdata = '0;
    for (int k = 0; k < NumOfImages; k++) begin
      if (i_valid[k]) begin
        if (lane < Lanes) begin
          o_we[k]                      = 1'b1;
          o_wdata[k*BitSize +: BitSize] = i_data[lane*BitSize +: BitSize];
        end
        lane = lane + 1;
      end
    end
  end

endmodule

// File: rtl/flattening_layer.sv
// Flattening layer: collects NumOfImages interleaved feature-map streams of ImageSize pixels.
// A complete set moves to an output buffer, which emits one whole image per cycle.
// While one set is emitted, the next set is collected.
// Ports:
//   clk        clock, rising edge
//   res_n      asynchronous reset, active-high
//   in_valid   bit k: one pixel of image k is present this cycle
//   in_data    L pixel lanes, lane 0 in the LSBs
//   out_ready  input is accepted this cycle
//   out_valid  out_data holds one complete image
//   out_data   current image, pixel 0 in the LSBs; zero when out_valid is low
module flattening_layer
  import flattening_layer_pkg::*;
#(
  parameter int unsigned BitSize         = 4,
  parameter int unsigned ImageSize       = 4,
  parameter int unsigned NumOfImages     = 4,
  parameter int unsigned NumOfInputs     = 2,
  parameter int unsigned NumOfPEPerInput = 1,
  parameter int unsigned CyclesPerPixel  = 2
) (
  input  logic                                        clk,
  input  logic                                        res_n,
  input  logic [NumOfImages-1:0]                      in_valid,
  input  logic [NumOfInputs*NumOfPEPerInput*BitSize-1:0] in_data,
  output logic                                        out_ready,
  output logic                                        out_valid,
  output logic [ImageSize*BitSize-1:0]                out_data
);

  localparam int unsigned Lanes = NumOfInputs * NumOfPEPerInput;
  localparam int unsigned CntW  = cnt_width(ImageSize + 1);
  localparam int unsigned EmitW = cnt_width(NumOfImages);
  localparam int unsigned ImgW  = ImageSize * BitSize;

  localparam logic [CntW-1:0]  CntFull  = CntW'(ImageSize);
  localparam logic [EmitW-1:0] EmitLast = EmitW'(NumOfImages - 1);

  // CyclesPerPixel describes the upstream pacing only; no logic depends on it.
  if (CyclesPerPixel == 0) begin : g_cpp_unpaced
  end

  logic [NumOfImages-1:0]            w_we;
  logic [NumOfImages*BitSize-1:0]    w_wdata;
  logic [NumOfImages-1:0]            w_img_full;
  logic                              w_full;
  logic                              w_free;
  logic                              w_xfer;
  logic [EmitW-1:0]                  w_emit_nxt;

  logic [NumOfImages-1:0][CntW-1:0]  r_cnt;
  logic [NumOfImages-1:0][ImgW-1:0]  r_coll;
  logic [NumOfImages-1:0][ImgW-1:0]  r_obuf;
  logic [EmitW-1:0]                  r_emit;
  logic [0:0]                        r_state;
  logic [ImgW-1:0]                   r_out_data;

  flattening_layer_lane_router #(
    .BitSize     (BitSize),
    .NumOfImages (NumOfImages),
    .Lanes       (Lanes)
  ) u_router (
    .i_valid (in_valid),
    .i_data  (in_data),
    .o_we    (w_we),
    .o_wdata (w_wdata)
  );

  always_comb begin
    w_img_full = '0;
    for (int k = 0; k < NumOfImages; k++) begin
      w_img_full[k] = (r_cnt[k] == CntFull);
    end
    w_full = &w_img_full;
    // The output side can take a set when idle, or on the edge that ends the last image.
    w_free     = (r_state == StIdle) || (r_emit == EmitLast);
    w_xfer     = w_full && w_free;
    w_emit_nxt = r_emit + EmitW'(1);
  end

  // Collection buffer and per-image fill counters.
  always_ff @(posedge clk or posedge res_n) begin
    if (res_n) begin
      r_cnt  <= '0;
      r_coll <= '0;
    end else if (w_xfer) begin
      r_cnt <= '0;
    end else if (!w_full) begin
      for (int k = 0; k < NumOfImages; k++) begin
        // A full image drops further pixels, so its counter saturates.
        if (w_we[k] && !w_img_full[k]) begin
          r_coll[k][r_cnt[k]*BitSize +: BitSize] <= w_wdata[k*BitSize +: BitSize];
          r_cnt[k]                               <= r_cnt[k] + CntW'(1);
        end
      end
    end
  end

  // Output buffer and emit FSM. Each image is shown for one cycle.
  always_ff @(posedge clk or posedge res_n) begin
    if (res_n) begin
      r_state    <= StIdle;
      r_emit     <= '0;
      r_obuf     <= '0;
      r_out_data <= '0;
    end else if (w_xfer) begin
      r_obuf     <= r_coll;
      r_emit     <= '0;
      r_state    <= StEmit;
      r_out_data <= r_coll[0];
    end else if (r_state == StEmit) begin
      if (r_emit == EmitLast) begin
        r_state    <= StIdle;
        r_emit     <= '0;
        r_out_data <= '0;
      end else begin
        r_emit     <= w_emit_nxt;
        r_out_data <= r_obuf[w_emit_nxt];
      end
    end
  end

  assign out_ready = !w_full;
  assign out_valid = (r_state == StEmit);
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_flattening_layer.sv
// Directed bench for flattening_layer.
// dut1 uses the default parameters: L=2, four images of four pixels.
// dut2 uses L=4 and two-pixel images. There a set completes faster than it is emitted,
// which exercises overlap and backpressure.
module tb_flattening_layer;

  logic        clk = 1'b0;
  logic        res_n = 1'b1;

  logic [3:0]  in_valid1;
  logic [7:0]  in_data1;
  logic        out_ready1;
  logic        out_valid1;
  logic [15:0] out_data1;

  logic [3:0]  in_valid2;
  logic [15:0] in_data2;
  logic        out_ready2;
  logic        out_valid2;
  logic [7:0]  out_data2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flattening_layer u_dut1 (
    .clk       (clk),
    .res_n     (res_n),
    .in_valid  (in_valid1),
    .in_data   (in_data1),
    .out_ready (out_ready1),
    .out_valid (out_valid1),
    .out_data  (out_data1)
  );

  flattening_layer #(
    .BitSize         (4),
    .ImageSize       (2),
    .NumOfImages     (4),
    .NumOfInputs     (2),
    .NumOfPEPerInput (2),
    .CyclesPerPixel  (1)
  ) u_dut2 (
    .clk       (clk),
    .res_n     (res_n),
    .in_valid  (in_valid2),
    .in_data   (in_data2),
    .out_ready (out_ready2),
    .out_valid (out_valid2),
    .out_data  (out_data2)
  );

  typedef struct {
    logic [3:0]  iv;
    logic [7:0]  id;
    logic        er;
    logic        ev;
    logic [15:0] ed;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [3:0] iv, input logic [7:0] id, input logic er,
                              input logic ev, input logic [15:0] ed);
    vec_t v;
    v.iv = iv;
    v.id = id;
    v.er = er;
    v.ev = ev;
    v.ed = ed;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Check dut1 outputs (state after the previous edge), then drive this cycle's inputs.
  task automatic step1(input string tag, input logic [3:0] iv, input logic [7:0] id,
                       input logic er, input logic ev, input logic [15:0] ed);
    @(negedge clk);
    chk({tag, ".ready"}, 32'(out_ready1), 32'(er));
    chk({tag, ".valid"}, 32'(out_valid1), 32'(ev));
    chk({tag, ".data"},  32'(out_data1),  32'(ed));
    in_valid1 = iv;
    in_data1  = id;
  endtask

  task automatic step2(input string tag, input logic [3:0] iv, input logic [15:0] id,
                       input logic er, input logic ev, input logic [7:0] ed);
    @(negedge clk);
    chk({tag, ".ready"}, 32'(out_ready2), 32'(er));
    chk({tag, ".valid"}, 32'(out_valid2), 32'(ev));
    chk({tag, ".data"},  32'(out_data2),  32'(ed));
    in_valid2 = iv;
    in_data2  = id;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".ready1"}, 32'(out_ready1), 32'd1);
    chk({tag, ".valid1"}, 32'(out_valid1), 32'd0);
    chk({tag, ".data1"},  32'(out_data1),  32'd0);
    chk({tag, ".ready2"}, 32'(out_ready2), 32'd1);
    chk({tag, ".valid2"}, 32'(out_valid2), 32'd0);
  endtask

  initial begin
    in_valid1 = '0;
    in_data1  = '0;
    in_valid2 = '0;
    in_data2  = '0;

    // Reset held for two cycles; the outputs sit at their reset values.
    #1;
    check_reset_state("rst0");
    @(negedge clk);
    check_reset_state("rst1");
    @(negedge clk);
    check_reset_state("rst2");
    res_n = 1'b0;
    step1("idle0", 4'b0000, 8'h00, 1'b1, 1'b0, 16'h0);
    step1("idle1", 4'b0000, 8'h00, 1'b1, 1'b0, 16'h0);

    // Set 1: A = 1100 lanes{1,3}, B = 0011 lanes{2,4}. Images hold 2,4,1,3.
    for (int i = 0; i < 4; i++) begin
      add(4'b1100, 8'h31, 1'b1, 1'b0, 16'h0);
      add(4'b0011, 8'h42, 1'b1, 1'b0, 16'h0);
    end
    add(4'b0000, 8'h00, 1'b0, 1'b0, 16'h0);        // full, waiting one edge
    // Set 2 starts as soon as the counters clear. 0101 lanes{5,6}, 1010 lanes{7,8}.
    add(4'b0101, 8'h65, 1'b1, 1'b1, 16'h2222);
    add(4'b1010, 8'h87, 1'b1, 1'b1, 16'h4444);
    add(4'b0101, 8'h65, 1'b1, 1'b1, 16'h1111);
    add(4'b1010, 8'h87, 1'b1, 1'b1, 16'h3333);
    for (int i = 0; i < 2; i++) begin
      add(4'b0101, 8'h65, 1'b1, 1'b0, 16'h0);
      add(4'b1010, 8'h87, 1'b1, 1'b0, 16'h0);
    end
    add(4'b0000, 8'h00, 1'b0, 1'b0, 16'h0);
    // Set 3: 1111 with two lanes writes only images 0 and 1. Extra pixels go to full images.
    add(4'b1111, 8'hA9, 1'b1, 1'b1, 16'h5555);
    add(4'b1111, 8'hA9, 1'b1, 1'b1, 16'h7777);
    add(4'b1111, 8'hA9, 1'b1, 1'b1, 16'h6666);
    add(4'b1111, 8'hA9, 1'b1, 1'b1, 16'h8888);
    add(4'b0001, 8'h0F, 1'b1, 1'b0, 16'h0);        // 5th pixel to image 0: dropped
    add(4'b1111, 8'hEE, 1'b1, 1'b0, 16'h0);        // pairs with full images 0/1: dropped
    for (int i = 0; i < 4; i++) add(4'b1100, 8'hCB, 1'b1, 1'b0, 16'h0);
    add(4'b0000, 8'h00, 1'b0, 1'b0, 16'h0);
    add(4'b0000, 8'h00, 1'b1, 1'b1, 16'h9999);
    add(4'b0000, 8'h00, 1'b1, 1'b1, 16'hAAAA);
    add(4'b0000, 8'h00, 1'b1, 1'b1, 16'hBBBB);
    add(4'b0000, 8'h00, 1'b1, 1'b1, 16'hCCCC);
    add(4'b0000, 8'h00, 1'b1, 1'b0, 16'h0);
    add(4'b0000, 8'h00, 1'b1, 1'b0, 16'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      step1($sformatf("vec%0d", i), vecs[i].iv, vecs[i].id, vecs[i].er, vecs[i].ev, vecs[i].ed);
    end

    // dut2: set A, then set B completes while A is still emitting.
    // Set B waits with out_ready low and follows A with no gap.
    step2("ov0",  4'b1111, 16'h4321, 1'b1, 1'b0, 8'h00);
    step2("ov1",  4'b1111, 16'h8765, 1'b1, 1'b0, 8'h00);
    step2("ov2",  4'b0000, 16'h0000, 1'b0, 1'b0, 8'h00);
    step2("ov3",  4'b1111, 16'hCBA9, 1'b1, 1'b1, 8'h51);
    step2("ov4",  4'b1111, 16'h0FED, 1'b1, 1'b1, 8'h62);
    step2("bp0",  4'b1111, 16'h1111, 1'b0, 1'b1, 8'h73);
    step2("bp1",  4'b1111, 16'h1111, 1'b0, 1'b1, 8'h84);
    step2("bp2",  4'b0000, 16'h0000, 1'b1, 1'b1, 8'hD9);
    step2("bp3",  4'b0000, 16'h0000, 1'b1, 1'b1, 8'hEA);
    step2("bp4",  4'b0000, 16'h0000, 1'b1, 1'b1, 8'hFB);
    step2("bp5",  4'b0000, 16'h0000, 1'b1, 1'b1, 8'h0C);
    step2("bp6",  4'b0000, 16'h0000, 1'b1, 1'b0, 8'h00);

    // dut1: reset after three of eight input cycles. Only the post-reset set may appear.
    step1("mid0", 4'b1100, 8'hDD, 1'b1, 1'b0, 16'h0);
    step1("mid1", 4'b0011, 8'hDD, 1'b1, 1'b0, 16'h0);
    step1("mid2", 4'b1100, 8'hDD, 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    in_valid1 = '0;
    in_data1  = '0;
    res_n     = 1'b1;
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    res_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step1($sformatf("post%0dA", i), 4'b1100, 8'h31, 1'b1, 1'b0, 16'h0);
      step1($sformatf("post%0dB", i), 4'b0011, 8'h42, 1'b1, 1'b0, 16'h0);
    end
    step1("post_full", 4'b0000, 8'h00, 1'b0, 1'b0, 16'h0);
    step1("post_e0",   4'b0000, 8'h00, 1'b1, 1'b1, 16'h2222);
    step1("post_e1",   4'b0000, 8'h00, 1'b1, 1'b1, 16'h4444);
    step1("post_e2",   4'b0000, 8'h00, 1'b1, 1'b1, 16'h1111);
    step1("post_e3",   4'b0000, 8'h00, 1'b1, 1'b1, 16'h3333);
    step1("post_end",  4'b0000, 8'h00, 1'b1, 1'b0, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flattening_layer.md
Name: flattening_layer

Overview:
- Flattening stage between the last convolution/pooling layer and the dense layers.
- Collects `NumOfImages` feature-map streams of `ImageSize` pixels each, arriving interleaved over shared input lanes, into a collection buffer.
- Once every image is complete, the set is moved to an output buffer and emitted one whole image per cycle.
- The two buffers let the next set be collected while the previous set is emitted.

Parameters:
- BitSize, 4, width of one pixel word.
- ImageSize, 4, pixels per image (flattened length of one feature map).
- NumOfImages, 4, number of feature maps (channels) per set.
- NumOfInputs, 2, number of upstream input groups.
- NumOfPEPerInput, 1, lanes per input group; total lanes L = NumOfInputs*NumOfPEPerInput.
- CyclesPerPixel, 2, nominal upstream cycles per pixel position; informational only, no logic depends on it.

Ports:
- clk  in  1  single clock, rising edge.
- res_n  in  1  asynchronous reset, active-high (asserted when 1).
- in_valid  in  NumOfImages  bit k = 1: one pixel of image k is present this cycle.
- in_data  in  L*BitSize  L pixel lanes, lane 0 in the LSBs.
- out_ready  out  1  module accepts input this cycle.
- out_valid  out  1  out_data holds one complete image.
- out_data  out  ImageSize*BitSize  pixel 0 of the image in the LSBs.

Behaviour:
- Reset (async, active-high):
  - Clears all pixel counters, both buffers, the full flag and the emit counter.
  - out_valid=0, out_data=0, out_ready=1.
  - Reset mid-operation discards partial and pending sets; the first post-reset pixel is pixel 0.
- Lane mapping:
  - Set bits of in_valid, taken in ascending image index, are paired with lanes 0,1,2,... in ascending order.
  - Set bits beyond the L-th are ignored; unused lanes are ignored.
- Accept: on a rising edge with out_ready=1, each paired image k stores its lane word at position cnt[k], then cnt[k]++.
  - cnt[k] is a per-image counter of width clog2(ImageSize+1).
  - Writes to an image whose cnt[k]==ImageSize are dropped; that counter saturates.
  - Images fill independently, in any interleaving.
- Full: when every cnt[k]==ImageSize after an edge, the collection buffer is full.
  - out_ready is held 0 while full and not yet transferred.
  - Input is ignored while out_ready=0.
- Transfer happens at the first edge where the collection buffer is full and the output side is free.
  - Free means idle, or out_valid=1 with the emit counter on the last image.
  - At that edge: the output buffer is loaded, the emit counter is set to 0, all cnt are cleared, out_ready returns to 1, and out_valid=1 from that edge.
- Latency: the last pixel is accepted at edge T; with the output idle, out_valid rises at edge T+1 showing image 0.
- Emit: free-running, independent of in_valid.
  - Image e is shown for one cycle, then e+1.
  - After image NumOfImages-1: load the next set if full, otherwise out_valid=0 and out_data=0.
  - Output is registered; out_data is 0 whenever out_valid=0.
  - There is no downstream backpressure.
- Pixel arriving on the same edge as a transfer is not possible: out_ready is 0 before the transfer, so there is no conflict.
- All arithmetic is pass-through; no sign or width conversion.

Decomposition:
- Shared package (e.g. cnn_pkg):
  - pixel type: logic [BitSize-1:0];
  - clog2-based counter width helper.
- One natural sub-module: flatten_lane_router.
  - Combinational.
  - Maps in_valid/in_data to per-image write enables and data using a prefix-popcount of in_valid.
- Buffers, counters and the emit FSM (IDLE, EMIT) stay in the top.

Test Plan:
1. Reset and idle:
   - Stimulus: hold res_n=1 for 2 cycles, then release with in_valid=0.
   - Required: out_valid=0, out_data=0, out_ready=1 throughout.
2. Interleaved fill, default parameters:
   - Stimulus: for i=0..3, cycle A has in_valid=4'b1100 with lanes {0:1,1:3}; cycle B has in_valid=4'b0011 with lanes {0:2,1:4}.
   - Stored per image: image0=2, image1=4, image2=1, image3=3 (lane0→image2 and lane1→image3 in cycle A; lane0→image0 and lane1→image1 in cycle B).
   - Required: out_valid rises one cycle after the 8th input cycle.
   - Required: out_data = 0x2222, 0x4444, 0x1111, 0x3333 on consecutive cycles, then out_valid=0.
3. Overlap:
   - Stimulus: start a second set immediately after the first completes.
   - Required: out_ready stays 1; the second set is emitted directly after the first with no gap if it completes in time.
4. Backpressure:
   - Stimulus: complete set B while set A is still emitting.
   - Required: out_ready=0 until the transfer; valid pixels offered during that time are not stored; B is emitted right after A's last image.
5. Overflow and extra bits:
   - Stimulus: in_valid=4'b1111 with L=2; also send a 5th pixel to an already full image.
   - Required: only images 0 and 1 are written; the extra pixel is dropped; all emitted values are unchanged.
6. Reset mid-collection:
   - Stimulus: assert res_n after 3 of the 8 input cycles, then send a full set.
   - Required: only the post-reset data appears on out_data.
